// File: rtl/pwr_reg_target.sv
// AXI-Lite responder exposing a bank of power-control registers to the power-domain logic.
// Optional: define PWR_REG_WSTRB_EN to honour wstrb byte lanes on writes.
module pwr_reg_target #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [ADDR_WIDTH-1:0]         araddr,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [REG_NUM*DATA_WIDTH-1:0] regs_o,
  output logic [REG_NUM-1:0]            wr_pulse_o
);

  localparam int unsigned           IDX_W       = $clog2(REG_NUM);
  localparam int unsigned           STRB_W      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN        = ADDR_WIDTH'(REG_NUM * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_hit, ar_hit, commit;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] wr_word;

  // Address decode relative to the bank base; low two address bits are don't-care.
  assign aw_off = aw_addr_q - BASE_ADDR;
  assign ar_off = araddr - BASE_ADDR;
  assign aw_hit = aw_off < SPAN;
  assign ar_hit = ar_off < SPAN;
  assign aw_idx = aw_off[2 +: IDX_W];
  assign ar_idx = ar_off[2 +: IDX_W];

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid || rready;
  assign commit  = aw_held && w_held && (!bvalid || bready);

`ifdef PWR_REG_WSTRB_EN
  // Merge strobed byte lanes over the current register contents.
  always_comb begin
    wr_word = regs_q[aw_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (w_strb_q[b]) wr_word[8*b +: 8] = w_data_q[8*b +: 8];
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^w_strb_q;

  always_comb begin
    wr_word = w_data_q;
  end
`endif

  // Write address holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
    end else if (awvalid && !aw_held) begin
      aw_held   <= 1'b1;
      aw_addr_q <= awaddr;
    end
  end

  // Write data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      w_held <= 1'b0;
    end else if (wvalid && !w_held) begin
      w_held   <= 1'b1;
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // Register file commit, write strobes and B response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      wr_pulse_o <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
        if (aw_hit) begin
          regs_q[aw_idx]     <= wr_word;
          wr_pulse_o[aw_idx] <= 1'b1;
        end
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read response; sees pre-commit contents when racing a write to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= ar_hit ? regs_q[ar_idx] : '0;
      rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < REG_NUM; i++) regs_o[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_pwr_reg_target.sv
// Directed scoreboard bench for pwr_reg_target (16 registers at a non-zero base).
module tb_pwr_reg_target;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned NREG = 16;
`ifdef PWR_REG_WSTRB_EN
  localparam bit          STRB_EN = 1'b1;
  localparam logic [31:0] EXP_STRB_WORD = 32'h11BB_33DD;
`else
  localparam bit          STRB_EN = 1'b0;
  localparam logic [31:0] EXP_STRB_WORD = 32'hAABB_CCDD;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NREG*32-1:0] regs_o;
  logic [NREG-1:0]    wr_pulse_o;

  always #5 clk = ~clk;

  pwr_reg_target #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(NREG), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  logic [31:0] model [NREG];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          pulse_cnt [NREG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(NREG * 4)) return 2'b10;
    for (int b = 0; b < 4; b++) begin
      if (s[b] || !STRB_EN) model[off[5:2]][8*b +: 8] = d[8*b +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(NREG * 4)) return {2'b10, 32'h0};
    return {2'b00, model[off[5:2]]};
  endfunction

  function automatic int reg_mismatch();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (regs_o[32*i +: 32] !== model[i]) n++;
    return n;
  endfunction

  function automatic int pulse_total();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += pulse_cnt[i];
    return n;
  endfunction

  // Response monitor: pops the scoreboard on each B/R handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 64'(bvalid), 64'(0));
        else chk("bresp", 64'(bresp), 64'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 64'(rvalid), 64'(0));
        else chk("rresp_rdata", 64'({rresp, rdata}), 64'(exp_r.pop_front()));
      end
      for (int i = 0; i < NREG; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    exp_b.push_back(model_write(a, d, s));
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", 64'({aw_done, w_done}), 64'(2'b11));
  endtask

  task automatic do_read(input logic [31:0] a);
    bit done = 1'b0, hs;
    exp_r.push_back(model_read(a));
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      hs = arvalid && arready;
      step();
      if (hs) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    chk("rd_accept", 64'(done), 64'(1));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && (exp_b.size() != 0 || exp_r.size() != 0 || bvalid || rvalid); n++)
      step();
    chk("idle_b_queue", 64'(exp_b.size()), 64'(0));
    chk("idle_r_queue", 64'(exp_r.size()), 64'(0));
    @(negedge clk);
    chk("regs_vs_model", 64'(reg_mismatch()), 64'(0));
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_readies"}, 64'({awready, wready, arready}), 64'(3'b111));
    chk({tag, "_resp"}, 64'({bvalid, bresp, rvalid, rresp}), 64'(0));
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    chk({tag, "_pulse"}, 64'(wr_pulse_o), 64'(0));
    chk({tag, "_regs_nonzero"}, 64'(|regs_o), 64'(0));
  endtask

  initial begin : main
    logic [31:0] wa [3] = '{BASE + 32'h0C, BASE + 32'h10, BASE + 32'h44};
    logic [31:0] wd [3] = '{32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    logic [31:0] ra [3] = '{BASE + 32'h08, BASE + 32'h00, BASE + 32'h04};
    int  ai, wi, ri, p0, cnt, last;
    bit  hs_aw, hs_w, hs_ar;

    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset values, then reset asserted with an AW held and W still pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");
    step();
    rst_n = 1'b1;
    step();
    do_write(BASE, 32'h1234_5678, 4'hF);
    wait_idle();
    awaddr = BASE; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("held_awready", 64'(awready), 64'(0));
    chk("held_wready", 64'(wready), 64'(1));
    #2 rst_n = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    exp_b.delete(); exp_r.delete();
    @(negedge clk);
    chk_reset("rst_mid");
    step();
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    chk("no_b_after_reset", 64'(bvalid), 64'(0));
    step();
    do_read(BASE);
    wait_idle();

    // Aligned AW+W: bvalid and data visible two cycles after acceptance.
    exp_b.push_back(model_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF));
    awaddr = BASE + 32'h8; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("t2_c0_ready", 64'({awready, wready}), 64'(2'b11));
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("t2_c1_bvalid", 64'(bvalid), 64'(0));
    step();
    @(negedge clk);
    chk("t2_c2_bvalid", 64'(bvalid), 64'(1));
    chk("t2_c2_reg2", 64'(regs_o[95:64]), 64'(32'hDEAD_BEEF));
    chk("t2_c2_pulse", 64'(wr_pulse_o), 64'(16'h0004));
    step();
    @(negedge clk);
    chk("t2_c3_pulse", 64'(wr_pulse_o), 64'(0));
    step();
    wait_idle();

    // W three cycles ahead of AW.
    exp_b.push_back(model_write(BASE + 32'h4, 32'hCAFE_F00D, 4'hF));
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    @(negedge clk);
    chk("t3_wready_low", 64'(wready), 64'(0));
    step(); step();
    awaddr = BASE + 32'h4; awvalid = 1'b1;
    @(negedge clk);
    chk("t3_aw_cycle_bvalid", 64'({awready, bvalid}), 64'(2'b10));
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("t3_commit_cycle_bvalid", 64'(bvalid), 64'(0));
    step();
    @(negedge clk);
    chk("t3_bvalid", 64'(bvalid), 64'(1));
    chk("t3_pulse", 64'(wr_pulse_o), 64'(16'h0002));
    chk("t3_wready_free", 64'(wready), 64'(1));
    step();
    wait_idle();
    exp_r.push_back(model_read(BASE + 32'h4));
    araddr = BASE + 32'h4; arvalid = 1'b1;
    @(negedge clk);
    chk("t3_ar_cycle", 64'({arready, rvalid}), 64'(2'b10));
    step();
    arvalid = 1'b0;
    @(negedge clk);
    chk("t3_rvalid", 64'(rvalid), 64'(1));
    step();
    wait_idle();

    // Out of range on both sides of the window, plus the last in-range register.
    p0 = pulse_total();
    do_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    do_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF);
    wait_idle();
    chk("t4_no_pulse", 64'(pulse_total() - p0), 64'(0));
    do_read(BASE + 32'h40);
    do_read(BASE - 32'h4);
    wait_idle();
    p0 = pulse_cnt[15];
    do_write(BASE + 32'h3E, 32'h0F0F_5A5A, 4'hF);
    wait_idle();
    chk("t4_last_pulse", 64'(pulse_cnt[15] - p0), 64'(1));
    do_read(BASE + 32'h3C);
    wait_idle();

    // Backpressure: five-plus stalled cycles with continuous traffic, then drain.
    bready = 1'b0; rready = 1'b0;
    ai = 0; wi = 0; ri = 0;
    awaddr = wa[0]; wdata = wd[0]; wstrb = 4'hF; araddr = ra[0];
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int c = 0; c < 40 && !(c > 7 && ai == 3 && wi == 3 && ri == 3); c++) begin
      if (c == 7) begin
        chk("bp_aw_accepts", 64'(ai), 64'(2));
        chk("bp_w_accepts", 64'(wi), 64'(2));
        chk("bp_ar_accepts", 64'(ri), 64'(1));
        bready = 1'b1; rready = 1'b1;
      end
      @(negedge clk);
      if (c >= 3 && c < 7) begin
        chk("bp_readies", 64'({awready, wready, arready}), 64'(0));
        chk("bp_b_hold", 64'({bvalid, bresp}), 64'(3'b100));
        chk("bp_r_hold", 64'({rvalid, rresp, rdata}), 64'({3'b100, 32'hDEAD_BEEF}));
      end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_ar = arvalid && arready;
      step();
      if (hs_aw) begin
        exp_b.push_back(model_write(wa[ai], wd[ai], 4'hF));
        ai++;
        if (ai < 3) awaddr = wa[ai]; else awvalid = 1'b0;
      end
      if (hs_w) begin
        wi++;
        if (wi < 3) wdata = wd[wi]; else wvalid = 1'b0;
      end
      if (hs_ar) begin
        exp_r.push_back(model_read(ra[ri]));
        ri++;
        if (ri < 3) araddr = ra[ri]; else arvalid = 1'b0;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("bp_all_accepted", 64'({ai[1:0], wi[1:0], ri[1:0]}), 64'(6'b111111));
    wait_idle();

    // Back-to-back writes with bready high: one accepted every two cycles.
    awaddr = BASE + 32'h14; wdata = 32'h7000_0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; cnt = 0; last = 0;
    for (int c = 0; c < 20 && cnt < 4; c++) begin
      @(negedge clk);
      hs_aw = awvalid && awready && wvalid && wready;
      step();
      if (hs_aw) begin
        exp_b.push_back(model_write(awaddr, wdata, 4'hF));
        cnt++; last = c;
        awaddr = awaddr + 32'h4; wdata = wdata + 32'h1;
        if (cnt == 4) begin awvalid = 1'b0; wvalid = 1'b0; end
      end
    end
    chk("tput_count", 64'(cnt), 64'(4));
    chk("tput_last_cycle", 64'(last), 64'(6));
    wait_idle();

    // Byte strobes.
    do_write(BASE + 32'h4, 32'h1122_3344, 4'hF);
    do_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101);
    wait_idle();
    chk("t6_strobe_word", 64'(regs_o[63:32]), 64'(EXP_STRB_WORD));
    do_read(BASE + 32'h4);
    wait_idle();
    p0 = pulse_cnt[1];
    do_write(BASE + 32'h4, 32'h0000_0000, 4'h0);
    wait_idle();
    chk("t6_zero_strb_pulse", 64'(pulse_cnt[1] - p0), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
